rns_mod_addsub_pipe: RTL



---
 rtl/rns_pkg.sv | 19 +
 rtl/rns_mod_correct.sv | 41 ++++
 rtl/rns_mod_addsub_pipe.sv | 107 ++++++++++
 3 files changed

// File: rtl/rns_pkg.sv
// Shared RNS definitions: op encoding, modulus legality check and default moduli.
// Imported by the per-channel modular add/sub pipeline and its correction stage.
package rns_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int NUM_CH = 3;
  localparam int DEFAULT_MODULI [0:NUM_CH-1] = '{251, 253, 255};

  function automatic bit rns_modulus_ok(
    input int width,
    input int modulus
  );
    return (width >= 1) && (width <= 30) &&
           (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/rns_mod_correct.sv
// Combinational modular correction of a raw add/sub value (s, op -> result, wrap).
// Shared with the RNS accumulator.
module rns_mod_correct
  import rns_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 251
) (
  input  logic [WIDTH:0]   i_s,
  input  logic             i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_wrap
);

  localparam logic [WIDTH:0]   M_EXT = (WIDTH+1)'(MODULUS);
  // Truncation is harmless: the fix-ups are only meaningful modulo 2^WIDTH.
  localparam logic [WIDTH-1:0] M_LO  = WIDTH'(MODULUS);

  logic             w_ge;
  logic [WIDTH-1:0] w_add_fix;
  logic [WIDTH-1:0] w_sub_fix;

  assign w_ge      = (i_s >= M_EXT);
  assign w_add_fix = i_s[WIDTH-1:0] - M_LO;
  assign w_sub_fix = i_s[WIDTH-1:0] + M_LO;

  always_comb begin
    o_result = i_s[WIDTH-1:0];
    o_wrap   = 1'b0;
    if (i_op == OP_SUB) begin
      if (i_s[WIDTH]) begin
        o_result = w_sub_fix;
        o_wrap   = 1'b1;
      end
    end else if (w_ge) begin
      o_result = w_add_fix;
      o_wrap   = 1'b1;
    end
  end

endmodule

// File: rtl/rns_mod_addsub_pipe.sv
// Two-stage modulo-M add/sub for one RNS channel with valid/ready backpressure.
// Optional operand range check enabled by defining RNS_RANGE_CHECK_EN.
module rns_mod_addsub_pipe
  import rns_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 251
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wrap,
  output logic             err
);

  if (!rns_modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $fatal(1, "rns_mod_addsub_pipe: MODULUS %0d illegal for WIDTH %0d",
           MODULUS, WIDTH);
  end

  logic [WIDTH:0]   r_s1_s;
  logic             r_s1_op;
  logic             r_s1_err;
  logic             r_s1_valid;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_wrap;
  logic             r_err;

  logic [WIDTH:0]   w_raw;
  logic             w_err_raw;
  logic             w_s2_free;
  logic             w_in_ready;
  logic [WIDTH-1:0] w_corr;
  logic             w_corr_wrap;

  assign w_raw = (sub == OP_SUB) ? ({1'b0, a} - {1'b0, b})
                                 : ({1'b0, a} + {1'b0, b});

`ifdef RNS_RANGE_CHECK_EN
  localparam logic [WIDTH:0] M_EXT = (WIDTH+1)'(MODULUS);
  assign w_err_raw = ({1'b0, a} >= M_EXT) || ({1'b0, b} >= M_EXT);
`else
  assign w_err_raw = 1'b0;
`endif

  // S1 may move on whenever S2 is empty or being drained this cycle.
  assign w_s2_free  = !r_out_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_free;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_s     <= '0;
      r_s1_op    <= OP_ADD;
      r_s1_err   <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_s   <= w_raw;
        r_s1_op  <= sub;
        r_s1_err <= w_err_raw;
      end
    end
  end

  rns_mod_correct #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_correct (
    .i_s      (r_s1_s),
    .i_op     (r_s1_op),
    .o_result (w_corr),
    .o_wrap   (w_corr_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_wrap      <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_s2_free) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= r_s1_err ? '0 : w_corr;
        r_wrap   <= !r_s1_err && w_corr_wrap;
        r_err    <= r_s1_err;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign wrap      = r_wrap;
  assign err       = r_err;

endmodule
